// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: PC register, imem req/ack handshake,
// held fetch word for decode, delay-slot branch/jump redirect buffer.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        br_valid,
  input  logic [1:0]  br_op,
  input  logic        br_taken,
  input  logic [31:0] br_pc,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] jr_addr,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic        if_adel,
  output logic [31:0] if_instr
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        valid, valid_n;
  logic [31:0] instr, instr_n;
  logic        adel, adel_n;
  logic        pend_valid, pend_n;
  logic [31:0] pend_target, ptgt_n;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] br_seq;
  logic [31:0] br_off;
  logic [31:0] seq_pc;

  assign br_seq = br_pc + 32'd4;
  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};
  assign seq_pc = pc + 32'd4;

  always_comb begin
    redirect = 1'b0;
    target   = 32'd0;
    unique case (br_op)
      2'b01: begin
        redirect = br_valid & br_taken;
        target   = br_seq + br_off;
      end
      2'b10: begin
        redirect = br_valid;
        target   = {br_seq[31:28], imm26, 2'b00};
      end
      2'b11: begin
        redirect = br_valid;
        target   = jr_addr;
      end
      default: begin
        redirect = 1'b0;
        target   = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      valid       <= 1'b0;
      instr       <= 32'd0;
      adel        <= 1'b0;
      pend_valid  <= 1'b0;
      pend_target <= 32'd0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      valid       <= valid_n;
      instr       <= instr_n;
      adel        <= adel_n;
      pend_valid  <= pend_n;
      pend_target <= ptgt_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    valid_n  = valid;
    instr_n  = instr;
    adel_n   = adel;
    pend_n   = pend_valid;
    ptgt_n   = pend_target;
    imem_req = 1'b0;
    // Newer redirect always overwrites an older buffered one.
    if (redirect) begin
      pend_n = 1'b1;
      ptgt_n = target;
    end
    unique case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        if (pc[1:0] != 2'b00) begin
          instr_n = 32'd0;
          adel_n  = 1'b1;
          valid_n = 1'b1;
          state_n = VALID;
        end else begin
          imem_req = 1'b1;
          if (imem_ack) begin
            instr_n = imem_rdata;
            valid_n = 1'b1;
            state_n = VALID;
          end
        end
      end
      VALID: begin
        if (!stall) begin
          pc_n    = redirect   ? target      :
                    pend_valid ? pend_target : seq_pc;
          valid_n = 1'b0;
          adel_n  = 1'b0;
          pend_n  = 1'b0;
          state_n = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign imem_addr = pc;
  assign if_pc     = pc;
  assign if_pc4    = seq_pc;
  assign if_valid  = valid;
  assign if_instr  = instr;
  assign if_adel   = adel;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, reset-in-fetch
// sequence, and randomized run against an instruction-level model.
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        imem_ack = 1'b0;
  logic        br_valid = 1'b0;
  logic [1:0]  br_op = 2'b00;
  logic        br_taken = 1'b0;
  logic [31:0] br_pc = 32'd0;
  logic [15:0] imm16 = 16'd0;
  logic [25:0] imm26 = 26'd0;
  logic [31:0] jr_addr = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_instr;
  logic        if_adel;

  fetch_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .br_valid(br_valid),
    .br_op(br_op),
    .br_taken(br_taken),
    .br_pc(br_pc),
    .imm16(imm16),
    .imm26(imm26),
    .jr_addr(jr_addr),
    .if_valid(if_valid),
    .if_pc(if_pc),
    .if_pc4(if_pc4),
    .if_instr(if_instr),
    .if_adel(if_adel)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_A5A5;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        st;
    logic        ak;
    logic        bv;
    logic [1:0]  op;
    logic        tk;
    logic [31:0] bpc;
    logic [15:0] i16;
    logic [25:0] i26;
    logic [31:0] jr;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_instr;
    logic        e_adel;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic st, input logic ak, input logic rq,
                     input logic [31:0] pc, input logic vl,
                     input logic [31:0] ins, input logic ad);
    vec_t v;
    v.st = st; v.ak = ak; v.bv = 1'b0; v.op = 2'b00; v.tk = 1'b0;
    v.bpc = 32'd0; v.i16 = 16'd0; v.i26 = 26'd0; v.jr = 32'd0;
    v.e_req = rq; v.e_pc = pc; v.e_valid = vl;
    v.e_instr = ins; v.e_adel = ad;
    vecs.push_back(v);
  endtask

  task automatic add_br(input logic [1:0] op, input logic tk,
                        input logic [31:0] bpc, input logic [15:0] i16,
                        input logic [25:0] i26, input logic [31:0] jr);
    vec_t v;
    v = vecs.pop_back();
    v.bv = 1'b1; v.op = op; v.tk = tk; v.bpc = bpc;
    v.i16 = i16; v.i26 = i26; v.jr = jr;
    vecs.push_back(v);
  endtask

  // Higher-level model of one control transfer's target.
  function automatic logic [31:0] model_target(
      input logic [1:0] op, input logic [31:0] bpc,
      input logic [15:0] i16, input logic [25:0] i26,
      input logic [31:0] jr);
    int off;
    logic [31:0] nxt;
    off = $signed(i16);
    nxt = bpc + 32'd4;
    if (op == 2'b01) return nxt + 32'(off * 4);
    if (op == 2'b10)
      return (nxt & 32'hF000_0000) | ({6'd0, i26} * 32'd4);
    return jr;
  endfunction

  logic [31:0] exp_pc, redir_t, burst_addr, held;
  logic        redir_v, in_burst, prev_valid, consume;
  int          bursts, wait_left, since;

  initial begin
    // Reset values
    #12;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_pc", if_pc, RST_PC);
    check("rst_pc4", if_pc4, RST_PC + 32'd4);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_adel", {31'd0, if_adel}, 32'd0);

    row(0, 1, 0, 32'h3000, 0, 0, 0);
    row(0, 1, 1, 32'h3000, 0, 0, 0);
    row(0, 0, 0, 32'h3000, 1, mem_word(32'h3000), 0);
    row(0, 1, 1, 32'h3004, 0, 0, 0);
    row(0, 0, 0, 32'h3004, 1, mem_word(32'h3004), 0);
    row(0, 0, 1, 32'h3008, 0, 0, 0);
    row(0, 0, 1, 32'h3008, 0, 0, 0);
    row(0, 0, 1, 32'h3008, 0, 0, 0);
    row(0, 1, 1, 32'h3008, 0, 0, 0);
    row(1, 1, 0, 32'h3008, 1, mem_word(32'h3008), 0);
    row(1, 1, 0, 32'h3008, 1, mem_word(32'h3008), 0);
    row(0, 0, 0, 32'h3008, 1, mem_word(32'h3008), 0);
    row(0, 0, 1, 32'h300C, 0, 0, 0);
    add_br(2'b01, 1, 32'h3008, 16'hFFFF, 26'd0, 32'd0);
    row(0, 1, 1, 32'h300C, 0, 0, 0);
    row(0, 0, 0, 32'h300C, 1, mem_word(32'h300C), 0);
    row(0, 1, 1, 32'h3008, 0, 0, 0);
    add_br(2'b01, 0, 32'h3004, 16'h0010, 26'd0, 32'd0);
    row(0, 0, 0, 32'h3008, 1, mem_word(32'h3008), 0);
    row(0, 1, 1, 32'h300C, 0, 0, 0);
    row(0, 0, 0, 32'h300C, 1, mem_word(32'h300C), 0);
    add_br(2'b10, 0, 32'h3010, 16'd0, 26'h0000C10, 32'd0);
    row(0, 1, 1, 32'h3040, 0, 0, 0);
    row(1, 0, 0, 32'h3040, 1, mem_word(32'h3040), 0);
    add_br(2'b11, 0, 32'd0, 16'd0, 26'd0, 32'h3100);
    row(0, 0, 0, 32'h3040, 1, mem_word(32'h3040), 0);
    row(0, 1, 1, 32'h3100, 0, 0, 0);
    add_br(2'b11, 0, 32'd0, 16'd0, 26'd0, 32'h3102);
    row(0, 0, 0, 32'h3100, 1, mem_word(32'h3100), 0);
    row(0, 1, 0, 32'h3102, 0, 0, 0);
    row(1, 0, 0, 32'h3102, 1, 32'd0, 1);
    row(1, 0, 0, 32'h3102, 1, 32'd0, 1);

    @(posedge clk);
    #1;
    reset = 1'b1;
    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      check($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, v.e_req});
      check($sformatf("v%0d_addr", i), imem_addr, v.e_pc);
      check($sformatf("v%0d_pc4", i), if_pc4, v.e_pc + 32'd4);
      check($sformatf("v%0d_valid", i), {31'd0, if_valid},
            {31'd0, v.e_valid});
      if (v.e_valid) begin
        check($sformatf("v%0d_instr", i), if_instr, v.e_instr);
        check($sformatf("v%0d_adel", i), {31'd0, if_adel},
              {31'd0, v.e_adel});
      end
      stall = v.st; imem_ack = v.ak; br_valid = v.bv; br_op = v.op;
      br_taken = v.tk; br_pc = v.bpc; imm16 = v.i16; imm26 = v.i26;
      jr_addr = v.jr;
      step();
    end

    // Reset during FETCH with a pending redirect and an ack outstanding
    br_valid = 1'b1; br_op = 2'b11; jr_addr = 32'h3200;
    stall = 1'b1; imem_ack = 1'b0;
    step();
    br_valid = 1'b0; stall = 1'b0;
    step();
    check("rf_req", {31'd0, imem_req}, 32'd1);
    check("rf_addr", imem_addr, 32'h3200);
    br_valid = 1'b1; br_op = 2'b10; br_pc = 32'h3000; imm26 = 26'h100;
    step();
    br_valid = 1'b0;
    check("rf_req2", {31'd0, imem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rf_req_drop", {31'd0, imem_req}, 32'd0);
    check("rf_pc", if_pc, RST_PC);
    check("rf_valid", {31'd0, if_valid}, 32'd0);
    imem_ack = 1'b1;
    step();
    reset = 1'b1;
    check("rf_idle_req", {31'd0, imem_req}, 32'd0);
    step();
    check("rf_fetch_addr", imem_addr, RST_PC);
    check("rf_fetch_req", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    check("rf_valid2", {31'd0, if_valid}, 32'd1);
    check("rf_instr", if_instr, mem_word(RST_PC));
    step();
    check("rf_next_pc", if_pc, RST_PC + 32'd4);

    // Randomized run against instruction-level model
    reset = 1'b0;
    step();
    reset = 1'b1;
    exp_pc = RST_PC; redir_v = 1'b0; redir_t = 32'd0;
    in_burst = 1'b0; burst_addr = 32'd0; bursts = 0; wait_left = 0;
    prev_valid = 1'b0; since = 0; held = 32'd0;
    for (int k = 0; k < 4000; k++) begin
      if (imem_req) begin
        if (!in_burst) begin
          in_burst = 1'b1;
          bursts++;
          burst_addr = imem_addr;
          wait_left = $urandom_range(0, 3);
        end else begin
          check("rnd_addr_stable", imem_addr, burst_addr);
        end
      end else begin
        in_burst = 1'b0;
      end
      if (if_valid && !prev_valid) begin
        check("rnd_pc", if_pc, exp_pc);
        check("rnd_pc4", if_pc4, exp_pc + 32'd4);
        check("rnd_adel", {31'd0, if_adel},
              {31'd0, exp_pc[1:0] != 2'b00});
        check("rnd_instr", if_instr,
              (exp_pc[1:0] != 2'b00) ? 32'd0 : mem_word(exp_pc));
        check("rnd_bursts", bursts, (exp_pc[1:0] != 2'b00) ? 0 : 1);
        bursts = 0;
        since = 0;
        held = if_instr;
      end else begin
        if (if_valid) check("rnd_hold", if_instr, held);
        since++;
        if (since > 40) begin
          n_checks++;
          n_fail++;
          $display("FAIL rnd_timeout: no delivery for %0d cycles", since);
          break;
        end
      end
      if (imem_req) begin
        imem_ack = (wait_left == 0);
        if (wait_left > 0) wait_left--;
      end else begin
        imem_ack = ($urandom_range(0, 7) == 0);
      end
      stall = ($urandom_range(0, 2) == 0);
      if (k > 0 && $urandom_range(0, 3) == 0) begin
        br_valid = 1'b1;
        br_op = 2'($urandom_range(0, 3));
        br_taken = 1'($urandom_range(0, 1));
        br_pc = {$urandom} & 32'hFFFF_FFFC;
        imm16 = 16'($urandom);
        imm26 = 26'($urandom);
        jr_addr = {$urandom} & 32'h0000_FFFC;
        if ($urandom_range(0, 15) == 0) jr_addr[1:0] = 2'b10;
        if ((br_op == 2'b01 && br_taken) || br_op[1]) begin
          redir_v = 1'b1;
          redir_t = model_target(br_op, br_pc, imm16, imm26, jr_addr);
        end
      end else begin
        br_valid = 1'b0;
      end
      consume = if_valid && !stall;
      if (consume) begin
        exp_pc = redir_v ? redir_t : exp_pc + 32'd4;
        redir_v = 1'b0;
      end
      prev_valid = if_valid;
      step();
    end
    br_valid = 1'b0;
    imem_ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer for the MIPS core: owns the PC register, runs a request/acknowledge handshake with instruction memory, and holds the fetched word until the decode stage accepts it. Branch/jump resolutions from decode are buffered and applied after the delay-slot instruction, with MIPS delay-slot semantics. It replaces the stateless next-PC path with a stall-aware, variable-latency fetch controller.

## Interface
- RESET_PC, 32'h0000_3000, PC value after reset
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  decode cannot accept the held instruction this cycle
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address, equals if_pc
- imem_ack  in  1  instruction memory returns imem_rdata this cycle
- imem_rdata  in  32  fetched word
- br_valid  in  1  one-cycle pulse: a control-transfer instruction in decode has resolved
- br_op  in  2  00 none, 01 conditional branch, 10 j/jal, 11 jr/jalr
- br_taken  in  1  branch condition result, used only for br_op=01
- br_pc  in  32  PC of the control-transfer instruction
- imm16  in  16  branch offset
- imm26  in  26  jump index
- jr_addr  in  32  register target for br_op=11
- if_valid  out  1  if_instr/if_pc hold a valid instruction for decode
- if_pc  out  32  PC of the current fetch/held instruction
- if_pc4  out  32  if_pc + 4
- if_instr  out  32  held instruction word
- if_adel  out  1  held instruction has a misaligned PC (fetch suppressed)

## Operation
- States: IDLE, FETCH, VALID.
- IDLE: entered on reset; imem_req=0; unconditionally to FETCH next clock.
- FETCH: imem_req=1, imem_addr=if_pc held stable until imem_ack. On imem_ack: if_instr<=imem_rdata, if_valid<=1, go VALID. If if_pc[1:0]!=0: no request issued; next clock if_instr<=0, if_adel<=1, if_valid<=1, go VALID.
- VALID: if_valid=1, imem_req=0. If stall=1: hold all outputs. If stall=0 (instruction consumed): if_pc<=npc, if_valid<=0, if_adel<=0, pend_valid<=0, go FETCH.
- Target computation on br_valid (all mod 2^32): br_op=01 and br_taken: br_pc+4+(sext(imm16)<<2); 01 not taken or 00: no redirect; 10: {(br_pc+4)[31:28], imm26, 2'b00}; 11: jr_addr.
- A redirect sets pend_valid<=1, pend_target<=target.
- npc on consumption: pend_valid ? pend_target : if_pc+4. If a redirect arrives in the same cycle as consumption, the new target is used directly and pend_valid stays 0.
- Redirect while pend_valid=1 (branch in delay slot, illegal): newer target overwrites.
- imem_ack outside FETCH ignored. if_pc4 always if_pc+4, combinational.

## Timing
- Reset values: state=IDLE, if_pc=RESET_PC, if_pc4=RESET_PC+4, if_valid=0, if_instr=0, if_adel=0, imem_req=0, pend_valid=0, pend_target=0.
- Reset asserted mid-fetch: imem_req drops immediately (asynchronous); outstanding ack after release is ignored in IDLE.
- Minimum 2 cycles per instruction (FETCH with same-cycle ack, then VALID with stall=0); each extra wait cycle on imem_ack or stall adds one.
- if_valid rises the clock after imem_ack; falls the clock after consumption.
- The instruction in IF/VALID when br_valid pulses is the delay slot; it always executes and the redirect applies to the following fetch.
- Exactly one imem_req burst per instruction; imem_addr never changes while imem_req=1.

## Test plan
- Reset release, imem_ack tied 1, stall=0 -> imem_addr sequence 0x3000, 0x3004, 0x3008; if_valid every second cycle; if_pc4=0x3004 while if_pc=0x3000.
- imem_ack delayed 3 cycles at 0x3004 -> imem_req high 4 cycles, imem_addr stable 0x3004; if_valid then holds while stall=1 for 2 cycles, if_instr unchanged.
- br_valid, br_op=01, br_taken=1, br_pc=0x3000, imm16=0xFFFF while 0x3004 fetching -> 0x3004 delivered, next fetch 0x3000; same with br_taken=0 -> next fetch 0x3008.
- br_op=10, br_pc=0x3010, imm26=0x0000C10 in the consumption cycle of 0x3014 -> next fetch 0x0000_3040; br_op=11, jr_addr=0x3100 -> next fetch 0x3100.
- jr_addr=0x3102 -> after delay slot, no imem_req; if_valid=1, if_adel=1, if_instr=0, if_pc=0x3102.
- Reset asserted during FETCH with imem_ack pending -> imem_req=0 at once, if_pc=0x3000, pend_valid=0; refetch from 0x3000 after release.
